// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory responder.
//
// Contents:
//   dmem_resp_state_t  responder FSM states (IDLE, WAIT, RESP)
//   DMEM_WORD_BYTES    bytes per data-memory word
//   dmem_be_to_mask    expands 8 byte enables into a 64-bit bit mask
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  localparam int DMEM_WORD_BYTES = 8;

  function automatic logic [63:0] dmem_be_to_mask(input logic [7:0] be);
    logic [63:0] mask;
    for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Synchronous single-port 64-bit SRAM with per-byte write enables.
//
// Ports:
//   clk      clock; read and write both happen on the rising edge
//   en_i     access strobe for this edge
//   we_i     1 = write the enabled bytes, 0 = read the word into rdata_o
//   be_i     byte-lane write enables (ignored on reads)
//   idx_i    word index
//   wdata_i  lane-aligned write data
//   rdata_o  registered read data; holds its value until the next read
module dmem_sram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [7:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  // Read port only updates on a read access, so the last read word stays
  // stable for as long as the consumer needs it.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
          if (be_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port.
//
// Accepts one load/store request at a time over a valid/ready channel,
// waits LATENCY cycles to model a slow memory, commits the access to an
// internal byte-enable SRAM and returns read data plus an out-of-window
// error flag over a second valid/ready channel.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_valid_i    request present        req_ready_o   responder idle
//   req_we_i       1 = store, 0 = load    req_be_i      store byte enables
//   req_addr_i     byte address (bits [2:0] ignored)
//   req_wdata_i    lane-aligned store data
//   resp_valid_o   response present       resp_ready_i  requester accepts
//   resp_rdata_o   loaded word (0 for stores and errors)
//   resp_err_o     address outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*8)
//
// Optional build macro DMEM_RESPONDER_PERF_EN adds saturating 32-bit
// counters rd_count_o, wr_count_o and err_count_o, bumped on each
// completed response handshake.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [7:0]  req_be_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o
`ifdef DMEM_RESPONDER_PERF_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] err_count_o
`endif
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] LIMIT_ADDR = BASE_ADDR +
                                       64'(DEPTH_WORDS) * 64'(DMEM_WORD_BYTES);
  // Only meaningful for LATENCY >= 2; the LATENCY == 1 path skips WAIT.
  localparam logic [3:0]  WAIT_INIT  = 4'(LATENCY - 2);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             we_q, we_d;
  logic [7:0]       be_q, be_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             acc_err;
  logic [63:0]      addr_off;
  logic [IDX_W-1:0] acc_idx;

  logic             commit;
  logic             c_we;
  logic [7:0]       c_be;
  logic [IDX_W-1:0] c_idx;
  logic [63:0]      c_wdata;
  logic             c_err;

  logic             sram_en;
  logic [63:0]      sram_rdata;
  logic             unused_addr_bits;

  // Address decode of the incoming request.
  assign acc_err  = (req_addr_i < BASE_ADDR) || (req_addr_i >= LIMIT_ADDR);
  assign addr_off = req_addr_i - BASE_ADDR;
  assign acc_idx  = addr_off[IDX_W+2:3];
  assign unused_addr_bits = ^{addr_off[63:IDX_W+3], addr_off[2:0]};

  // The reset gate keeps every output low while rst is high, even in the
  // cycle before the state register has been cleared.
  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign resp_valid_o = (state_q == RESP) && !rst;
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !err_q && !we_q) ? sram_rdata : 64'd0;

  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    // Fields used on the commit edge: latched copies by default, the live
    // request when a LATENCY == 1 accept commits on the same edge.
    c_we    = we_q;
    c_be    = be_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_err   = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          be_d    = req_be_i;
          idx_d   = acc_idx;
          wdata_d = req_wdata_i;
          err_d   = acc_err;
          c_we    = req_we_i;
          c_be    = req_be_i;
          c_idx   = acc_idx;
          c_wdata = req_wdata_i;
          c_err   = acc_err;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset landing on the commit edge abandons the access.
  assign sram_en = commit && !c_err && !rst;

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request/response data: no reset needed, outputs are gated by state.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    be_q    <= be_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (c_we),
    .be_i    (c_be),
    .idx_i   (c_idx),
    .wdata_i (c_wdata),
    .rdata_o (sram_rdata)
  );

`ifdef DMEM_RESPONDER_PERF_EN
  logic        resp_hs;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  assign resp_hs = resp_valid_o && resp_ready_i;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (resp_hs) begin
      if (err_q) begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= 32'd0;
      wr_cnt_q  <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule
